// File: rtl/if_id_skid.sv
// Fetch/decode pipeline register with valid/ready handshake.
// SKID_EN=1 adds a second entry so in_ready_o comes straight from state.
// SKID_EN=0 is a single register whose ready looks through to out_ready_i.
// hold_flag_i at or above HOLD_LEVEL freezes the stage; flush_i empties it.
// An empty stage always presents BUBBLE on out_data_o.
module if_id_skid #(
    parameter int unsigned   DW         = 32,
    parameter logic [DW-1:0] BUBBLE     = DW'(32'h00000013),
    parameter int unsigned   HOLD_W     = 3,
    parameter int unsigned   HOLD_LEVEL = 1,
    parameter bit            SKID_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    output logic [1:0]        occupancy_o
);

    // Encoding equals the number of held entries, so occupancy_o is the state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    logic hold_en;
    logic skid_valid;
    logic in_fire;
    logic out_fire;

    // Stall decode and handshake qualifiers.
    always_comb begin
        hold_en    = (32'(hold_flag_i) >= HOLD_LEVEL);
        skid_valid = (state_q == StFull);
        if (SKID_EN) begin
            // Registered ready: depends only on state and the hold level.
            in_ready_o = !skid_valid && !hold_en;
        end else begin
            in_ready_o = ((state_q == StEmpty) || out_ready_i) && !hold_en;
        end
        out_valid_o = (state_q != StEmpty);
        in_fire     = in_valid_i && in_ready_o;
        out_fire    = out_valid_o && out_ready_i && !hold_en;
    end

    assign out_data_o  = main_q;
    assign occupancy_o = state_q;

    // State and storage update: reset, then flush, then the handshake transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= BUBBLE;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Any in_fire this cycle is dropped; an out_fire was already taken downstream.
            state_q <= StEmpty;
            main_q  <= BUBBLE;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_q <= StOne;
                        main_q  <= in_data_i;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data_i;
                    end else if (out_fire) begin
                        state_q <= StEmpty;
                        main_q  <= BUBBLE;
                    end else if (in_fire && SKID_EN) begin
                        state_q <= StFull;
                        skid_q  <= in_data_i;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    main_q  <= BUBBLE;
                end
            endcase
        end
    end

    // An invalid output must still carry the bubble.
    a_bubble_when_idle : assert property (@(posedge clk) disable iff (rst)
        !out_valid_o |-> (out_data_o == BUBBLE));

    // Occupancy is bounded by the storage actually present.
    a_occ_bound : assert property (@(posedge clk) disable iff (rst)
        (occupancy_o <= (SKID_EN ? 2'd2 : 2'd1)));

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: one instance with skid, one without, each checked every
// cycle against a small queue model, plus directed cases with literal expectations.
module tb_if_id_skid;

    localparam logic [31:0] BUB = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_flush, a_iv, a_ir, a_or, a_ov;
    logic [2:0]  a_hold;
    logic [31:0] a_id, a_od;
    logic [1:0]  a_occ;

    logic        b_rst, b_flush, b_iv, b_ir, b_or, b_ov;
    logic [2:0]  b_hold;
    logic [31:0] b_id, b_od;
    logic [1:0]  b_occ;

    int total  = 0;
    int passed = 0;

    // Reference model: per instance, an ordered list of held payloads.
    logic [31:0] m_e [2][2];
    int          m_n [2];
    bit          armed [2];
    bit          rand_phase = 1'b0;
    bit          seen_c8    = 1'b0;

    if_id_skid #(.DW(32), .SKID_EN(1'b1)) dut_a (
        .clk        (clk),
        .rst        (a_rst),
        .flush_i    (a_flush),
        .hold_flag_i(a_hold),
        .in_valid_i (a_iv),
        .in_ready_o (a_ir),
        .in_data_i  (a_id),
        .out_valid_o(a_ov),
        .out_ready_i(a_or),
        .out_data_o (a_od),
        .occupancy_o(a_occ)
    );

    if_id_skid #(.DW(32), .SKID_EN(1'b0)) dut_b (
        .clk        (clk),
        .rst        (b_rst),
        .flush_i    (b_flush),
        .hold_flag_i(b_hold),
        .in_valid_i (b_iv),
        .in_ready_o (b_ir),
        .in_data_i  (b_id),
        .out_valid_o(b_ov),
        .out_ready_i(b_or),
        .out_data_o (b_od),
        .occupancy_o(b_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare one instance against the model, then advance the model by this cycle's inputs.
    task automatic step(input int k, input bit skid, input string pfx,
                        input logic rst_s, input logic fl, input logic [2:0] hold_s,
                        input logic iv, input logic [31:0] id, input logic ordy,
                        input logic ir, input logic ov, input logic [31:0] od,
                        input logic [1:0] occ);
        bit          hold, e_ir, in_f, out_f;
        logic [31:0] e_od;
        hold = (hold_s >= 3'd1);
        if (skid) e_ir = (m_n[k] < 2) && !hold;
        else      e_ir = ((m_n[k] == 0) || (ordy === 1'b1)) && !hold;
        e_od = (m_n[k] > 0) ? m_e[k][0] : BUB;
        if (armed[k]) begin
            chk({pfx, ".in_ready"},  32'(ir),  32'(e_ir));
            chk({pfx, ".out_valid"}, 32'(ov),  32'(m_n[k] > 0));
            chk({pfx, ".out_data"},  od,       e_od);
            chk({pfx, ".occupancy"}, 32'(occ), 32'(m_n[k]));
        end
        if (rst_s === 1'b1) begin
            m_n[k]   = 0;
            armed[k] = 1'b1;
        end else if (armed[k]) begin
            in_f  = (iv === 1'b1) && e_ir;
            out_f = (m_n[k] > 0) && (ordy === 1'b1) && !hold;
            if (fl === 1'b1) begin
                m_n[k] = 0;
            end else begin
                if (out_f) begin
                    m_e[k][0] = m_e[k][1];
                    m_n[k]--;
                end
                if (in_f) begin
                    m_e[k][m_n[k]] = id;
                    m_n[k]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        step(0, 1'b1, "skid", a_rst, a_flush, a_hold, a_iv, a_id, a_or, a_ir, a_ov, a_od, a_occ);
        step(1, 1'b0, "noskid", b_rst, b_flush, b_hold, b_iv, b_id, b_or, b_ir, b_ov, b_od,
             b_occ);
        if (!rand_phase && a_ov === 1'b1 && a_od === 32'hC8) seen_c8 = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_n[0] = 0; m_n[1] = 0;
        armed[0] = 1'b0; armed[1] = 1'b0;
        a_rst = 1'b1; a_flush = 1'b0; a_hold = 3'd0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_hold = 3'd0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;
        cyc();
        cyc();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state.
        chk("rst.out_valid", 32'(a_ov), 32'd0);
        chk("rst.out_data", a_od, 32'h00000013);
        chk("rst.occupancy", 32'(a_occ), 32'd0);
        chk("rst.in_ready", 32'(a_ir), 32'd1);

        // Streaming at one payload per cycle.
        a_iv = 1'b1; a_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_id = 32'h100 + 32'(4 * i);
            cyc();
            chk("stream.data", a_od, 32'h100 + 32'(4 * i));
            chk("stream.occ", 32'(a_occ), 32'd1);
        end
        a_iv = 1'b0;
        cyc();
        chk("stream.drain_valid", 32'(a_ov), 32'd0);

        // Backpressure into the skid entry.
        a_or = 1'b0; a_iv = 1'b1; a_id = 32'hA0;
        cyc();
        a_id = 32'hA4;
        cyc();
        chk("skid.occ", 32'(a_occ), 32'd2);
        chk("skid.in_ready", 32'(a_ir), 32'd0);
        chk("skid.head", a_od, 32'hA0);
        a_iv = 1'b0; a_or = 1'b1;
        cyc();
        chk("skid.second", a_od, 32'hA4);
        chk("skid.occ_one", 32'(a_occ), 32'd1);
        cyc();
        chk("skid.empty", 32'(a_ov), 32'd0);

        // Hold freezes a valid entry.
        a_iv = 1'b1; a_id = 32'hB0; a_or = 1'b0;
        cyc();
        a_hold = 3'b010; a_id = 32'hB4; a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold.in_ready", 32'(a_ir), 32'd0);
            chk("hold.data", a_od, 32'hB0);
            chk("hold.valid", 32'(a_ov), 32'd1);
        end
        a_hold = 3'd0; a_iv = 1'b0;
        cyc();
        chk("hold.released", 32'(a_ov), 32'd0);

        // Flush from FULL with a payload presented.
        a_or = 1'b0; a_iv = 1'b1; a_id = 32'hC0;
        cyc();
        a_id = 32'hC4;
        cyc();
        chk("flush.full", 32'(a_occ), 32'd2);
        a_flush = 1'b1; a_id = 32'hC8;
        cyc();
        chk("flush.valid", 32'(a_ov), 32'd0);
        chk("flush.data", a_od, BUB);
        chk("flush.occ", 32'(a_occ), 32'd0);
        a_flush = 1'b0; a_iv = 1'b0;
        cyc();
        chk("flush.after", 32'(a_ov), 32'd0);

        // Flush from ONE while in_fire and out_fire both happen.
        a_iv = 1'b1; a_id = 32'hD0;
        cyc();
        a_flush = 1'b1; a_id = 32'hC8; a_or = 1'b1;
        cyc();
        chk("flush1.valid", 32'(a_ov), 32'd0);
        chk("flush1.occ", 32'(a_occ), 32'd0);
        a_flush = 1'b0; a_iv = 1'b0;
        cyc();
        chk("flush1.after", 32'(a_ov), 32'd0);

        // Single-register variant: ready looks through to out_ready_i.
        b_iv = 1'b1; b_or = 1'b1; b_id = 32'h200;
        cyc();
        chk("noskid.first", b_od, 32'h200);
        chk("noskid.ready1", 32'(b_ir), 32'd1);
        b_id = 32'h204; b_or = 1'b0;
        #1;
        chk("noskid.ready0", 32'(b_ir), 32'd0);
        cyc();
        chk("noskid.stall", b_od, 32'h200);
        chk("noskid.occ", 32'(b_occ), 32'd1);
        b_or = 1'b1;
        #1;
        chk("noskid.ready_again", 32'(b_ir), 32'd1);
        cyc();
        chk("noskid.second", b_od, 32'h204);
        b_iv = 1'b0;
        cyc();
        chk("noskid.empty", 32'(b_ov), 32'd0);
        chk("no_c8_seen", 32'(seen_c8), 32'd0);

        // Randomized traffic on both instances.
        rand_phase = 1'b1;
        repeat (800) begin
            a_rst   = ($urandom_range(0, 99) == 0);
            a_flush = ($urandom_range(0, 19) == 0);
            a_hold  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            a_iv    = ($urandom_range(0, 3) != 0);
            a_or    = ($urandom_range(0, 2) != 0);
            a_id    = $urandom;
            b_rst   = ($urandom_range(0, 99) == 0);
            b_flush = ($urandom_range(0, 19) == 0);
            b_hold  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            b_iv    = ($urandom_range(0, 3) != 0);
            b_or    = ($urandom_range(0, 2) != 0);
            b_id    = $urandom;
            cyc();
        end
        a_rst = 1'b0; a_flush = 1'b0; a_hold = 3'd0; a_iv = 1'b0; a_or = 1'b1;
        b_rst = 1'b0; b_flush = 1'b0; b_hold = 3'd0; b_iv = 1'b0; b_or = 1'b1;
        repeat (4) cyc();
        chk("final.a_empty", 32'(a_ov), 32'd0);
        chk("final.b_empty", 32'(b_ov), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries an arbitrary-width payload (instruction, address, interrupt flags, concatenated by the instantiator) between two pipeline stages.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so the upstream ready path is fully registered.
- Keeps the codebase hold-level stall and adds a flush that injects a bubble (NOP payload).

Parameters:
- DW, 32: payload width in bits.
- BUBBLE, 32'h00000013 (resized to DW): payload presented whenever out_valid_o=0.
- HOLD_W, 3: width of hold_flag_i.
- HOLD_LEVEL, 1: stage stalls when hold_flag_i >= HOLD_LEVEL (unsigned compare).
- SKID_EN, 1: 1 = 2-entry skid with registered in_ready_o; 0 = single register with combinational ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held entries; highest priority.
- hold_flag_i  in  HOLD_W  pipeline hold level.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  output payload valid.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DW  output payload.
- occupancy_o  out  2  number of held entries (0..2).

Behaviour:
- Internal signals:
  - hold_en = (hold_flag_i >= HOLD_LEVEL).
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i & !hold_en.
- Storage:
  - main register (drives out_data_o/out_valid_o).
  - skid register plus skid_valid (present only when SKID_EN=1).
- Reset (rst=1 at an edge):
  - out_valid_o=0, skid_valid=0, occupancy_o=0, out_data_o=BUBBLE.
  - Reset wins over every other input.
- Invariant: out_data_o == BUBBLE whenever out_valid_o=0. Every transition into EMPTY loads BUBBLE into main.
- in_ready_o:
  - SKID_EN=1: !skid_valid & !hold_en. No combinational path from out_ready_i.
  - SKID_EN=0: (!out_valid_o | out_ready_i) & !hold_en.
- State machine, SKID_EN=1 (occupancy_o encodes the state):
  - EMPTY (0):
    - in_fire -> ONE, main<=in_data_i.
    - else stay.
  - ONE (1):
    - in_fire & out_fire -> ONE, main<=in_data_i.
    - out_fire only -> EMPTY, main<=BUBBLE.
    - in_fire only -> FULL, skid<=in_data_i.
    - neither -> stay.
  - FULL (2): in_ready_o=0.
    - out_fire -> ONE, main<=skid, skid_valid<=0.
    - else stay.
- SKID_EN=0: only EMPTY and ONE exist, with the same transitions; occupancy_o never exceeds 1.
- Latency:
  - 1 cycle from in_fire to out_valid_o in EMPTY.
  - A payload accepted into skid appears one cycle after the out_fire that drains main.
- Ordering: strict FIFO. No payload is duplicated or dropped except by flush/reset.
- Hold:
  - While hold_en=1: no in_fire, no out_fire, all state frozen.
  - out_valid_o/out_data_o stay driven but must not be consumed.
- Flush:
  - At the next edge: state -> EMPTY, skid_valid=0, main<=BUBBLE.
  - A payload presented with in_fire in the same cycle is discarded.
  - Flush overrides hold and any simultaneous in_fire/out_fire.
  - An out_fire in the flush cycle still counts as consumed downstream.
- Throughput: 1 payload/cycle sustained when out_ready_i=1 and hold_en=0, in both modes.
- Upstream contract: in_data_i must be stable while in_valid_i=1 & in_ready_o=0. Not checked by the block.

Test Plan:
- Reset, DW=32, SKID_EN=1:
  - Hold rst=1 for 2 cycles, then release -> out_valid_o=0, out_data_o=32'h00000013, occupancy_o=0, in_ready_o=1.
- Streaming:
  - in_valid_i=1 with payloads 0x100,0x104,0x108,0x10C on consecutive cycles, out_ready_i=1.
  - -> out_data_o shows 0x100..0x10C on the following 4 cycles, out_valid_o=1 throughout, occupancy_o=1.
- Backpressure/skid:
  - Send 0xA0,0xA4 with out_ready_i=0 -> occupancy_o=2, in_ready_o=0 on the next cycle.
  - Raise out_ready_i -> outputs 0xA0 then 0xA4, in order, with no loss.
- Hold:
  - With main=0xB0, drive hold_flag_i=3'b010 for 3 cycles with in_valid_i=1, out_ready_i=1 -> in_ready_o=0, state frozen, 0xB0 still valid.
  - Drop hold -> 0xB0 consumed next edge.
- Flush:
  - In FULL (0xC0,0xC4), assert flush_i together with in_valid_i=1 carrying 0xC8 -> next cycle out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0.
  - 0xC8 never appears on the output.
- SKID_EN=0 variant:
  - out_ready_i toggling 1,0,1 with continuous input -> in_ready_o follows out_ready_i combinationally when main is valid; order preserved; occupancy_o never exceeds 1.
